// File: rtl/div_seq_32b.sv
// div_seq_32b: sequential signed divider for the DIV instruction.
// One restoring shift-subtract step per clock on the operand magnitudes,
// followed by a sign-fix step. The quotient goes to LO and the remainder to HI.
//
//   state  | meaning
//   -------+------------------------------------------------------------
//   S_IDLE | waiting for i_start
//   S_CALC | one restoring step per edge, WIDTH steps in total
//   S_FIX  | apply the result signs and load the output registers
//   S_DONE | o_done pulse; a new i_start is accepted here as in S_IDLE
module div_seq_32b #(
   parameter int WIDTH = 32
) (
   input  logic             i_clk,
   input  logic             i_clr,
   input  logic             i_start,
   input  logic [WIDTH-1:0] i_dividend,
   input  logic [WIDTH-1:0] i_divisor,
   output logic             o_busy,
   output logic             o_done,
   output logic [WIDTH-1:0] o_quotient,
   output logic [WIDTH-1:0] o_remainder,
   output logic             o_div_by_zero
);

   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_CALC,
      S_FIX,
      S_DONE
   } state_t;

   state_t            r_state;
   state_t            w_next;

   logic [WIDTH-1:0]  r_q;
   logic [WIDTH-1:0]  r_rem;
   logic [WIDTH-1:0]  r_dvs;
   logic [CW-1:0]     r_cnt;
   logic              r_sign_q;
   logic              r_sign_r;
   logic [WIDTH-1:0]  r_quot_out;
   logic [WIDTH-1:0]  r_rem_out;
   logic              r_dbz;

   logic              w_accept;
   logic              w_div_zero;
   logic [WIDTH-1:0]  w_dvd_mag;
   logic [WIDTH-1:0]  w_dvs_mag;
   logic [WIDTH:0]    w_shift;
   logic [WIDTH:0]    w_trial;

   // Starts are honoured only when not busy: in IDLE, or back-to-back in DONE.
   assign w_accept   = i_start && ((r_state == S_IDLE) || (r_state == S_DONE));
   assign w_div_zero = (i_divisor == '0);

   // Plain WIDTH-bit negation: the most negative value maps onto itself, which
   // is the right magnitude when read as unsigned.
   assign w_dvd_mag = i_dividend[WIDTH-1] ? -i_dividend : i_dividend;
   assign w_dvs_mag = i_divisor[WIDTH-1]  ? -i_divisor  : i_divisor;

   // The partial remainder is always below the divisor, so WIDTH bits hold it;
   // only the shifted trial value needs the extra bit for the borrow.
   assign w_shift = {r_rem, r_q[WIDTH-1]};
   assign w_trial = w_shift - {1'b0, r_dvs};

   // State register.
   always_ff @(posedge i_clk) begin
      if (i_clr) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // Next-state decode.
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE: begin
            if (w_accept) begin
               w_next = w_div_zero ? S_DONE : S_CALC;
            end
         end
         S_CALC: begin
            if (r_cnt == LAST_STEP) begin
               w_next = S_FIX;
            end
         end
         S_FIX: begin
            w_next = S_DONE;
         end
         S_DONE: begin
            if (w_accept) begin
               w_next = w_div_zero ? S_DONE : S_CALC;
            end else begin
               w_next = S_IDLE;
            end
         end
         default: begin
            w_next = S_IDLE;
         end
      endcase
   end

   // Status outputs decode straight from the state register.
   always_comb begin
      o_busy = 1'b0;
      o_done = 1'b0;
      case (r_state)
         S_CALC,
         S_FIX:   o_busy = 1'b1;
         S_DONE:  o_done = 1'b1;
         default: ;
      endcase
   end

   // Operand capture, restoring steps and result registers.
   always_ff @(posedge i_clk) begin
      if (i_clr) begin
         r_q        <= '0;
         r_rem      <= '0;
         r_dvs      <= '0;
         r_cnt      <= '0;
         r_sign_q   <= 1'b0;
         r_sign_r   <= 1'b0;
         r_quot_out <= '0;
         r_rem_out  <= '0;
         r_dbz      <= 1'b0;
      end else if (w_accept) begin
         r_q      <= w_dvd_mag;
         r_dvs    <= w_dvs_mag;
         r_rem    <= '0;
         r_cnt    <= '0;
         r_sign_q <= i_dividend[WIDTH-1] ^ i_divisor[WIDTH-1];
         r_sign_r <= i_dividend[WIDTH-1];
         if (w_div_zero) begin
            r_quot_out <= '1;
            r_rem_out  <= i_dividend;
            r_dbz      <= 1'b1;
         end
      end else if (r_state == S_CALC) begin
         r_cnt <= r_cnt + CW'(1);
         if (!w_trial[WIDTH]) begin
            r_rem <= w_trial[WIDTH-1:0];
            r_q   <= {r_q[WIDTH-2:0], 1'b1};
         end else begin
            r_rem <= w_shift[WIDTH-1:0];
            r_q   <= {r_q[WIDTH-2:0], 1'b0};
         end
      end else if (r_state == S_FIX) begin
         r_quot_out <= r_sign_q ? -r_q : r_q;
         r_rem_out  <= r_sign_r ? -r_rem : r_rem;
         r_dbz      <= 1'b0;
      end
   end

   assign o_quotient    = r_quot_out;
   assign o_remainder   = r_rem_out;
   assign o_div_by_zero = r_dbz;

endmodule

// File: tb/tb_div_seq_32b.sv
// tb_div_seq_32b: scoreboard bench for div_seq_32b.
module tb_div_seq_32b;

   logic        i_clk;
   logic        i_clr;
   logic        i_start;
   logic [31:0] i_dividend;
   logic [31:0] i_divisor;
   logic        o_busy;
   logic        o_done;
   logic [31:0] o_quotient;
   logic [31:0] o_remainder;
   logic        o_div_by_zero;

   typedef struct {
      logic [31:0] q;
      logic [31:0] r;
      logic        dbz;
      int          cyc;
   } exp_t;

   exp_t sb_q[$];
   int   n_checks = 0;
   int   n_fail   = 0;
   int   cyc      = 0;
   int   done_cnt = 0;

   div_seq_32b #(.WIDTH(32)) u_dut (
      .i_clk         (i_clk),
      .i_clr         (i_clr),
      .i_start       (i_start),
      .i_dividend    (i_dividend),
      .i_divisor     (i_divisor),
      .o_busy        (o_busy),
      .o_done        (o_done),
      .o_quotient    (o_quotient),
      .o_remainder   (o_remainder),
      .o_div_by_zero (o_div_by_zero)
   );

   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   // Cycle number: the value after an edge is the number of the cycle it starts.
   always @(posedge i_clk) cyc <= cyc + 1;

   task automatic chk_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   function automatic exp_t model(input logic [31:0] a, input logic [31:0] b);
      exp_t e;
      logic signed [31:0] sa;
      logic signed [31:0] sd;
      sa = a;
      sd = b;
      e.cyc = 0;
      if (b == 32'd0) begin
         e.q = 32'hFFFF_FFFF;
         e.r = a;
         e.dbz = 1'b1;
      end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
         e.q = 32'h8000_0000;
         e.r = 32'd0;
         e.dbz = 1'b0;
      end else begin
         e.q = sa / sd;
         e.r = sa % sd;
         e.dbz = 1'b0;
      end
      return e;
   endfunction

   // Scoreboard: every done pulse pops one expected result.
   always @(negedge i_clk) begin
      if (o_done) begin
         exp_t e;
         done_cnt++;
         if (sb_q.size() == 0) begin
            chk_val("unexpected_done", 32'd1, 32'd0);
         end else begin
            e = sb_q.pop_front();
            chk_val("quotient", o_quotient, e.q);
            chk_val("remainder", o_remainder, e.r);
            chk_val("div_by_zero", {31'd0, o_div_by_zero}, {31'd0, e.dbz});
            chk_val("done_cycle", 32'(cyc), 32'(e.cyc));
         end
      end
   end

   // Drives start from the current point; operands are scrambled after acceptance.
   task automatic go(input logic [31:0] a, input logic [31:0] b, input bit push);
      exp_t e;
      i_start    = 1'b1;
      i_dividend = a;
      i_divisor  = b;
      @(posedge i_clk);
      #1;
      i_start    = 1'b0;
      i_dividend = $urandom;
      i_divisor  = $urandom;
      if (push) begin
         e = model(a, b);
         e.cyc = cyc + ((b == 32'd0) ? 0 : 33);
         sb_q.push_back(e);
      end
   endtask

   task automatic wait_done(input int limit);
      int n;
      n = 0;
      @(negedge i_clk);
      while (!o_done && n < limit) begin
         @(negedge i_clk);
         n++;
      end
      if (!o_done) chk_val("done_timeout", 32'd0, 32'd1);
   endtask

   task automatic run(input logic [31:0] a, input logic [31:0] b);
      @(negedge i_clk);
      go(a, b, 1'b1);
      wait_done(60);
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      int before_cnt;
      i_clr      = 1'b1;
      i_start    = 1'b0;
      i_dividend = '0;
      i_divisor  = '0;
      repeat (3) @(posedge i_clk);
      @(negedge i_clk);
      i_clr = 1'b0;
      chk_val("rst_busy", {31'd0, o_busy}, 32'd0);
      chk_val("rst_done", {31'd0, o_done}, 32'd0);
      chk_val("rst_quot", o_quotient, 32'd0);
      chk_val("rst_rem", o_remainder, 32'd0);
      chk_val("rst_dbz", {31'd0, o_div_by_zero}, 32'd0);

      // 7/2 with cycle-exact busy and done profile
      @(negedge i_clk);
      go(32'd7, 32'd2, 1'b1);
      for (int k = 1; k <= 34; k++) begin
         @(negedge i_clk);
         chk_val("busy_profile", {31'd0, o_busy}, (k <= 33) ? 32'd1 : 32'd0);
         chk_val("done_profile", {31'd0, o_done}, (k == 34) ? 32'd1 : 32'd0);
      end

      run(32'hFFFF_FFF9, 32'd2);
      run(32'd7, 32'hFFFF_FFFE);
      run(32'hFFFF_FFF9, 32'hFFFF_FFFE);
      run(32'h8000_0000, 32'hFFFF_FFFF);
      run(32'h7FFF_FFFF, 32'd1);
      run(32'h8000_0000, 32'd1);
      run(32'h8000_0000, 32'h8000_0000);
      run(32'd1, 32'h8000_0000);
      run(32'd0, 32'd5);
      run(32'd5, 32'd0);
      chk_val("dbz_busy", {31'd0, o_busy}, 32'd0);
      run(32'd9, 32'd3);
      for (int i = 0; i < 8; i++) begin
         run($urandom, $urandom_range(1, 32'hFFFF));
         run($urandom, $urandom);
      end

      // clr in mid-calculation aborts and clears everything
      @(negedge i_clk);
      go(32'd100, 32'd7, 1'b1);
      repeat (10) @(negedge i_clk);
      i_clr = 1'b1;
      @(posedge i_clk);
      #1;
      i_clr = 1'b0;
      sb_q.delete();
      before_cnt = done_cnt;
      @(negedge i_clk);
      chk_val("clr_busy", {31'd0, o_busy}, 32'd0);
      chk_val("clr_done", {31'd0, o_done}, 32'd0);
      chk_val("clr_quot", o_quotient, 32'd0);
      chk_val("clr_rem", o_remainder, 32'd0);
      chk_val("clr_dbz", {31'd0, o_div_by_zero}, 32'd0);
      repeat (40) @(negedge i_clk);
      chk_val("no_done_after_clr", 32'(done_cnt), 32'(before_cnt));
      run(32'd100, 32'd7);

      // start while busy is ignored; start in the done cycle is accepted
      @(negedge i_clk);
      go(32'd100, 32'd7, 1'b1);
      repeat (5) @(negedge i_clk);
      go(32'd1, 32'd1, 1'b0);
      wait_done(60);
      go(32'd20, 32'd6, 1'b1);
      wait_done(60);

      // clr and start on the same edge: clr wins
      @(negedge i_clk);
      i_clr = 1'b1;
      go(32'd50, 32'd5, 1'b0);
      i_clr = 1'b0;
      @(negedge i_clk);
      chk_val("clr_vs_start_busy", {31'd0, o_busy}, 32'd0);
      chk_val("clr_vs_start_done", {31'd0, o_done}, 32'd0);

      repeat (40) @(negedge i_clk);
      chk_val("sb_empty", 32'(sb_q.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/div_seq_32b.md
# div_seq_32b

Sequential 32-bit signed divider for the MiniSRC datapath, the subtractive counterpart to the single-cycle 64-bit carry-lookahead adder. It executes the DIV instruction: one restoring shift-subtract step per clock on operand magnitudes, then a sign-fix step. The quotient is written to LO and the remainder to HI. The control unit starts it with a one-cycle `start` and stalls until `done`.

## Interface
- `WIDTH`, 32: operand width. Only 32 is verified.
- `clk` in 1: rising-edge clock.
- `clr` in 1: synchronous, active-high reset.
- `start` in 1: request a division. Accepted only while `busy`=0.
- `dividend` in 32: two's-complement dividend. Sampled on the accepting edge.
- `divisor` in 32: two's-complement divisor. Sampled on the accepting edge.
- `busy` out 1: high from the cycle after acceptance until the cycle before `done`.
- `done` out 1: one-cycle pulse; results are valid in the same cycle.
- `quotient` out 32: quotient, to LO. Held until the next completed operation.
- `remainder` out 32: remainder, to HI. Held until the next completed operation.
- `div_by_zero` out 1: set with `done` when the sampled divisor was 0. Held like the results.

## Operation
- States are IDLE, CALC, FIX and DONE.
- IDLE → CALC on `start`:
  - Latch |dividend| into the quotient/shift register and |divisor| into the divisor register.
  - Clear the partial remainder to 0 and the step counter to 0.
  - Latch sign_q = dividend[31]^divisor[31] and sign_r = dividend[31].
- IDLE → DONE on `start` with divisor==0, skipping CALC:
  - `quotient` = 32'hFFFF_FFFF, `remainder` = dividend, `div_by_zero` = 1.
- CALC, one step per edge:
  - Shift {R,Q} left by one and form the trial value T = R − D, where R is 33 bits and D is the zero-extended divisor.
  - If T[32]=0: R←T and Q[0]←1. Otherwise keep R and Q[0]←0.
  - The counter increments each step. After the 32nd step (counter==31), go to FIX.
- FIX:
  - `quotient` ← sign_q ? −Q : Q.
  - `remainder` ← sign_r ? −R[31:0] : R[31:0].
  - `div_by_zero` ← 0. Go to DONE.
- DONE: `done`=1 for exactly one cycle, then IDLE. A `start` in DONE is accepted exactly as in IDLE.
- Arithmetic rules:
  - The quotient truncates toward zero.
  - The remainder takes the sign of the dividend, or is 0.
  - dividend = quotient·divisor + remainder for every non-overflow, non-zero-divisor case.
  - Magnitudes use 32-bit negation, so |0x8000_0000| = 0x8000_0000 read as unsigned, and this is correct.
  - Overflow: 0x8000_0000 / −1 gives quotient 0x8000_0000 and remainder 0. No flag is raised.
- Boundary conditions:
  - `start` while `busy`=1 is ignored, and the operands are not resampled.
  - Operand changes after the accepting edge have no effect.
  - `clr` at any point aborts the operation: state goes to IDLE, no `done` is produced, and all outputs are cleared.
  - If `clr` and `start` are high on the same edge, `clr` wins.

## Timing
- Reset values: `busy`=0, `done`=0, `quotient`=0, `remainder`=0, `div_by_zero`=0, state IDLE, counter 0.
- All outputs are registered; there are no combinational input-to-output paths.
- Normal division, with `start` sampled at the end of cycle 0:
  - CALC in cycles 1–32, FIX in cycle 33.
  - `done`=1 and results valid in cycle 34.
  - `busy`=1 in cycles 1–33.
  - Latency is 34 cycles.
- Divide by zero, with `start` sampled at the end of cycle 0:
  - DONE in cycle 1, with `done` and the results valid there.
  - `busy` never asserts.
  - Latency is 1 cycle.
- Back-to-back: a `start` in the `done` cycle yields the next `done` 34 cycles later. Sustained throughput is one division per 34 cycles.

## Test plan
- dividend=7, divisor=2, `start` in cycle 0 → `done` in cycle 34; quotient=3, remainder=1; `busy` high in cycles 1–33 exactly.
- −7/2 → quotient=0xFFFF_FFFD, remainder=0xFFFF_FFFF. 7/−2 → quotient=0xFFFF_FFFD, remainder=1. −7/−2 → quotient=3, remainder=0xFFFF_FFFF.
- 0x8000_0000 / 0xFFFF_FFFF → quotient=0x8000_0000, remainder=0, `div_by_zero`=0. 0x7FFF_FFFF / 1 → quotient=0x7FFF_FFFF, remainder=0.
- 5/0 → `done` in cycle 1; quotient=0xFFFF_FFFF, remainder=5, `div_by_zero`=1. Then 9/3 → `div_by_zero`=0, quotient=3, remainder=0.
- Start 100/7, then pulse `clr` in cycle 10 → no `done` ever appears and all outputs are 0. A fresh 100/7 then completes 34 cycles later with quotient=14, remainder=2.
- Start 100/7, then in cycle 5 assert `start` with 1/1 → the second start is ignored and the single `done` in cycle 34 carries quotient=14, remainder=2. A `start` with 20/6 in that `done` cycle → `done` in cycle 68 with quotient=3, remainder=2.
